// File: rtl/swc_wb_fabric_slice_pkg.sv
// Shared constants, request record and helpers for the Wishbone fabric slice.
package swc_wb_fabric_pkg;

    localparam int c_wb_fabric_data_width = 16;
    localparam int c_wb_fabric_addr_width = 2;
    localparam int c_wb_fabric_sel_width  = 2;

    // One request word as it travels through the skid buffer (default widths).
    typedef struct packed {
        logic [c_wb_fabric_addr_width-1:0] adr;
        logic [c_wb_fabric_data_width-1:0] dat;
        logic [c_wb_fabric_sel_width-1:0]  sel;
        logic                              we;
    } t_wb_req;

    // Outstanding counter must hold the value max_out itself, hence the extra bit.
    function automatic int f_cnt_width(input int max_out);
        return $clog2(max_out) + 1;
    endfunction

endpackage

// File: rtl/swc_wb_fabric_slice_chan.sv
// One fabric channel: 2-entry request skid buffer, outstanding tracking,
// registered response return and cycle-abort flush.
module swc_wb_fabric_slice_chan
    import swc_wb_fabric_pkg::*;
#(
    parameter int g_data_width      = c_wb_fabric_data_width,
    parameter int g_addr_width      = c_wb_fabric_addr_width,
    parameter int g_sel_width       = c_wb_fabric_sel_width,
    parameter int g_max_outstanding = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [g_data_width-1:0] snk_dat_i,
    input  logic [g_addr_width-1:0] snk_adr_i,
    input  logic [g_sel_width-1:0]  snk_sel_i,
    input  logic                    snk_cyc_i,
    input  logic                    snk_stb_i,
    input  logic                    snk_we_i,
    output logic                    snk_stall_o,
    output logic                    snk_ack_o,
    output logic                    snk_err_o,
    output logic                    snk_rty_o,
    output logic [g_data_width-1:0] src_dat_o,
    output logic [g_addr_width-1:0] src_adr_o,
    output logic [g_sel_width-1:0]  src_sel_o,
    output logic                    src_cyc_o,
    output logic                    src_stb_o,
    output logic                    src_we_o,
    input  logic                    src_stall_i,
    input  logic                    src_ack_i,
    input  logic                    src_err_i,
    input  logic                    src_rty_i
);

    localparam int c_cw = f_cnt_width(g_max_outstanding);

    typedef struct packed {
        logic [g_addr_width-1:0] adr;
        logic [g_data_width-1:0] dat;
        logic [g_sel_width-1:0]  sel;
        logic                    we;
    } t_chan_req;

    t_chan_req       r_main, r_skid;
    logic            r_main_vld, r_skid_vld;
    logic [c_cw-1:0] r_cnt;
    logic            r_stall, r_cyc, r_ack, r_err, r_rty;

    t_chan_req       w_in;
    logic            w_acc, w_iss, w_rsp, w_abort, w_cnt_nz;
    logic            w_main_vld_nxt, w_skid_vld_nxt;
    logic [c_cw-1:0] w_cnt_nxt;
    logic [c_cw:0]   w_fill;

    // Handshake decode; an abort is the upstream dropping cyc with work in flight.
    always_comb begin
        w_in.adr = snk_adr_i;
        w_in.dat = snk_dat_i;
        w_in.sel = snk_sel_i;
        w_in.we  = snk_we_i;
        w_cnt_nz = (r_cnt != '0);
        w_acc    = snk_cyc_i & snk_stb_i & ~r_stall;
        w_iss    = r_main_vld & ~src_stall_i;
        w_rsp    = (src_ack_i | src_err_i | src_rty_i) & w_cnt_nz;
        w_abort  = ~snk_cyc_i & (r_main_vld | r_skid_vld | w_cnt_nz);
    end

    // Next occupancy of buffer and counter; stall is derived from these so it can be registered.
    always_comb begin
        w_main_vld_nxt = r_main_vld;
        w_skid_vld_nxt = r_skid_vld;
        w_cnt_nxt      = r_cnt;
        if (w_abort) begin
            w_main_vld_nxt = 1'b0;
            w_skid_vld_nxt = 1'b0;
            w_cnt_nxt      = '0;
        end else begin
            if (w_iss) begin
                w_main_vld_nxt = r_skid_vld | w_acc;
                w_skid_vld_nxt = 1'b0;
            end else if (w_acc) begin
                if (r_main_vld) w_skid_vld_nxt = 1'b1;
                else            w_main_vld_nxt = 1'b1;
            end
            if (w_iss & ~w_rsp)      w_cnt_nxt = r_cnt + (c_cw)'(1);
            else if (~w_iss & w_rsp) w_cnt_nxt = r_cnt - (c_cw)'(1);
        end
        w_fill = (c_cw+1)'(w_cnt_nxt) + (c_cw+1)'(w_main_vld_nxt) + (c_cw+1)'(w_skid_vld_nxt);
    end

    // Payload registers: main loads from skid on promotion, else from the bus; skid only fills behind a held main.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_iss & r_skid_vld)                 r_main <= r_skid;
            else if (w_acc & (w_iss | ~r_main_vld)) r_main <= w_in;
            if (w_acc & r_main_vld & ~w_iss)        r_skid <= w_in;
        end
    end

    // Control state, registered stall/cyc and the one-cycle response return.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
            r_cnt      <= '0;
            r_stall    <= 1'b0;
            r_cyc      <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_rty      <= 1'b0;
        end else begin
            r_main_vld <= w_main_vld_nxt;
            r_skid_vld <= w_skid_vld_nxt;
            r_cnt      <= w_cnt_nxt;
            r_stall    <= w_skid_vld_nxt | (w_fill >= (c_cw+1)'(g_max_outstanding));
            r_cyc      <= ~w_abort & (w_acc | (r_cyc & snk_cyc_i));
            // Responses with nothing outstanding or outside an active cycle are stray and dropped.
            r_ack      <= src_ack_i & snk_cyc_i & w_cnt_nz;
            r_err      <= src_err_i & snk_cyc_i & w_cnt_nz;
            r_rty      <= src_rty_i & snk_cyc_i & w_cnt_nz;
        end
    end

    assign snk_stall_o = r_stall;
    assign snk_ack_o   = r_ack;
    assign snk_err_o   = r_err;
    assign snk_rty_o   = r_rty;
    assign src_cyc_o   = r_cyc;
    assign src_stb_o   = r_main_vld;
    assign src_adr_o   = r_main.adr;
    assign src_dat_o   = r_main.dat;
    assign src_sel_o   = r_main.sel;
    assign src_we_o    = r_main.we;

endmodule

// File: rtl/swc_wb_fabric_slice.sv
// N-channel Wishbone register slice; the top only unpacks flattened buses per channel.
module swc_wb_fabric_slice
    import swc_wb_fabric_pkg::*;
#(
    parameter int g_num_ports       = 11,
    parameter int g_data_width      = c_wb_fabric_data_width,
    parameter int g_addr_width      = c_wb_fabric_addr_width,
    parameter int g_sel_width       = c_wb_fabric_sel_width,
    parameter int g_max_outstanding = 8
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [g_num_ports*g_data_width-1:0] snk_dat_i,
    input  logic [g_num_ports*g_addr_width-1:0] snk_adr_i,
    input  logic [g_num_ports*g_sel_width-1:0]  snk_sel_i,
    input  logic [g_num_ports-1:0]              snk_cyc_i,
    input  logic [g_num_ports-1:0]              snk_stb_i,
    input  logic [g_num_ports-1:0]              snk_we_i,
    output logic [g_num_ports-1:0]              snk_stall_o,
    output logic [g_num_ports-1:0]              snk_ack_o,
    output logic [g_num_ports-1:0]              snk_err_o,
    output logic [g_num_ports-1:0]              snk_rty_o,
    output logic [g_num_ports*g_data_width-1:0] src_dat_o,
    output logic [g_num_ports*g_addr_width-1:0] src_adr_o,
    output logic [g_num_ports*g_sel_width-1:0]  src_sel_o,
    output logic [g_num_ports-1:0]              src_cyc_o,
    output logic [g_num_ports-1:0]              src_stb_o,
    output logic [g_num_ports-1:0]              src_we_o,
    input  logic [g_num_ports-1:0]              src_stall_i,
    input  logic [g_num_ports-1:0]              src_ack_i,
    input  logic [g_num_ports-1:0]              src_err_i,
    input  logic [g_num_ports-1:0]              src_rty_i
);

    for (genvar gi = 0; gi < g_num_ports; gi++) begin : g_chan
        swc_wb_fabric_slice_chan #(
            .g_data_width      (g_data_width),
            .g_addr_width      (g_addr_width),
            .g_sel_width       (g_sel_width),
            .g_max_outstanding (g_max_outstanding)
        ) u_chan (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .snk_dat_i   (snk_dat_i[gi*g_data_width +: g_data_width]),
            .snk_adr_i   (snk_adr_i[gi*g_addr_width +: g_addr_width]),
            .snk_sel_i   (snk_sel_i[gi*g_sel_width +: g_sel_width]),
            .snk_cyc_i   (snk_cyc_i[gi]),
            .snk_stb_i   (snk_stb_i[gi]),
            .snk_we_i    (snk_we_i[gi]),
            .snk_stall_o (snk_stall_o[gi]),
            .snk_ack_o   (snk_ack_o[gi]),
            .snk_err_o   (snk_err_o[gi]),
            .snk_rty_o   (snk_rty_o[gi]),
            .src_dat_o   (src_dat_o[gi*g_data_width +: g_data_width]),
            .src_adr_o   (src_adr_o[gi*g_addr_width +: g_addr_width]),
            .src_sel_o   (src_sel_o[gi*g_sel_width +: g_sel_width]),
            .src_cyc_o   (src_cyc_o[gi]),
            .src_stb_o   (src_stb_o[gi]),
            .src_we_o    (src_we_o[gi]),
            .src_stall_i (src_stall_i[gi]),
            .src_ack_i   (src_ack_i[gi]),
            .src_err_i   (src_err_i[gi]),
            .src_rty_i   (src_rty_i[gi])
        );
    end

endmodule

// File: tb/tb_swc_wb_fabric_slice.sv
// Directed bench: ch0 vector table, then hand sequences for stall, limit, abort, independence, reset.
module tb_swc_wb_fabric_slice;
    import swc_wb_fabric_pkg::*;

    localparam int N  = 11;
    localparam int DW = 16;
    localparam int AW = 2;
    localparam int SW = 2;
    localparam int MO = 4;

    logic clk = 1'b0;
    logic rst_i;
    logic [N*DW-1:0] snk_dat_i, src_dat_o;
    logic [N*AW-1:0] snk_adr_i, src_adr_o;
    logic [N*SW-1:0] snk_sel_i, src_sel_o;
    logic [N-1:0] snk_cyc_i, snk_stb_i, snk_we_i;
    logic [N-1:0] snk_stall_o, snk_ack_o, snk_err_o, snk_rty_o;
    logic [N-1:0] src_cyc_o, src_stb_o, src_we_o;
    logic [N-1:0] src_stall_i, src_ack_i, src_err_i, src_rty_i;

    int n_pass = 0;
    int n_tot  = 0;

    swc_wb_fabric_slice #(
        .g_num_ports(N), .g_data_width(DW), .g_addr_width(AW),
        .g_sel_width(SW), .g_max_outstanding(MO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .snk_dat_i(snk_dat_i), .snk_adr_i(snk_adr_i), .snk_sel_i(snk_sel_i),
        .snk_cyc_i(snk_cyc_i), .snk_stb_i(snk_stb_i), .snk_we_i(snk_we_i),
        .snk_stall_o(snk_stall_o), .snk_ack_o(snk_ack_o), .snk_err_o(snk_err_o), .snk_rty_o(snk_rty_o),
        .src_dat_o(src_dat_o), .src_adr_o(src_adr_o), .src_sel_o(src_sel_o),
        .src_cyc_o(src_cyc_o), .src_stb_o(src_stb_o), .src_we_o(src_we_o),
        .src_stall_i(src_stall_i), .src_ack_i(src_ack_i), .src_err_i(src_err_i), .src_rty_i(src_rty_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic    cyc;
        logic    stb;
        t_wb_req req;
        logic [3:0] rs;   // {stall, ack, err, rty} driven downstream
        logic [5:0] ef;   // expected {snk_stall, snk_ack, snk_err, snk_rty, src_cyc, src_stb}
        t_wb_req er;      // expected src request fields
    } vec_t;

    function automatic t_wb_req mkreq(logic [1:0] a, logic [15:0] d, logic [1:0] s, logic w);
        t_wb_req r;
        r.adr = a; r.dat = d; r.sel = s; r.we = w;
        return r;
    endfunction

    function automatic vec_t mk(logic c, logic s, t_wb_req r, logic [3:0] rs, logic [5:0] ef, t_wb_req er);
        vec_t v;
        v.cyc = c; v.stb = s; v.req = r; v.rs = rs; v.ef = ef; v.er = er;
        return v;
    endfunction

    function automatic t_wb_req got(input int ch);
        t_wb_req r;
        r.adr = src_adr_o[ch*AW +: AW];
        r.dat = src_dat_o[ch*DW +: DW];
        r.sel = src_sel_o[ch*SW +: SW];
        r.we  = src_we_o[ch];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drv(input int ch, input logic c, input logic s, input t_wb_req r);
        snk_cyc_i[ch] = c;
        snk_stb_i[ch] = s;
        snk_we_i[ch]  = r.we;
        snk_adr_i[ch*AW +: AW] = r.adr;
        snk_dat_i[ch*DW +: DW] = r.dat;
        snk_sel_i[ch*SW +: SW] = r.sel;
    endtask

    task automatic rsp(input int ch, input logic st, input logic a, input logic e, input logic r);
        src_stall_i[ch] = st;
        src_ack_i[ch]   = a;
        src_err_i[ch]   = e;
        src_rty_i[ch]   = r;
    endtask

    initial begin
        vec_t    tbl[14];
        t_wb_req z, wa, wb1, wb2, x;
        t_wb_req lw[6], bw[6], aw[4], sw[10], rw[3];
        logic [26:0] act;
        int na, ni, nak, st_left, st_start, st_seen, pend;
        logic st_started, st_now;

        z = mkreq(2'd0, 16'h0, 2'd0, 1'b0);
        rst_i = 1'b1;
        snk_dat_i = '0; snk_adr_i = '0; snk_sel_i = '0;
        snk_cyc_i = '0; snk_stb_i = '0; snk_we_i = '0;
        src_stall_i = '0; src_ack_i = '0; src_err_i = '0; src_rty_i = '0;
        tick(); tick();
        chk("reset_outputs", 64'({|snk_stall_o, |snk_ack_o, |snk_err_o, |snk_rty_o, |src_dat_o,
                                   |src_adr_o, |src_sel_o, |src_cyc_o, |src_stb_o, |src_we_o}), 64'(0));
        rst_i = 1'b0;

        // ---- ch0 vector table: single write, stray response, back-to-back, err/rty ----
        wa  = mkreq(2'd2, 16'hA5A5, 2'd3, 1'b1);
        wb1 = mkreq(2'd1, 16'h1234, 2'd1, 1'b0);
        wb2 = mkreq(2'd3, 16'hBEEF, 2'd2, 1'b1);
        tbl[0]  = mk(1, 1, wa,  4'b0000, 6'b000000, z);
        tbl[1]  = mk(1, 0, z,   4'b0000, 6'b000011, wa);
        tbl[2]  = mk(1, 0, z,   4'b0000, 6'b000010, wa);
        tbl[3]  = mk(1, 0, z,   4'b0100, 6'b000010, wa);
        tbl[4]  = mk(0, 0, z,   4'b0000, 6'b010010, wa);
        tbl[5]  = mk(0, 0, z,   4'b0000, 6'b000000, wa);
        tbl[6]  = mk(1, 0, z,   4'b0100, 6'b000000, wa);
        tbl[7]  = mk(1, 0, z,   4'b0000, 6'b000000, wa);
        tbl[8]  = mk(1, 1, wb1, 4'b0000, 6'b000000, wa);
        tbl[9]  = mk(1, 1, wb2, 4'b0000, 6'b000011, wb1);
        tbl[10] = mk(1, 0, z,   4'b0010, 6'b000011, wb2);
        tbl[11] = mk(1, 0, z,   4'b0001, 6'b001010, wb2);
        tbl[12] = mk(0, 0, z,   4'b0000, 6'b000110, wb2);
        tbl[13] = mk(0, 0, z,   4'b0000, 6'b000000, wb2);
        for (int i = 0; i < 14; i++) begin
            drv(0, tbl[i].cyc, tbl[i].stb, tbl[i].req);
            rsp(0, tbl[i].rs[3], tbl[i].rs[2], tbl[i].rs[1], tbl[i].rs[0]);
            act = {snk_stall_o[0], snk_ack_o[0], snk_err_o[0], snk_rty_o[0], src_cyc_o[0], src_stb_o[0], got(0)};
            chk($sformatf("vec%0d", i), 64'(act), 64'({tbl[i].ef, tbl[i].er}));
            tick();
        end

        // ---- ch1 outstanding limit (MO=4), downstream never acks ----
        for (int k = 0; k < 6; k++) lw[k] = mkreq(2'(k), 16'(16'h1100 + k), 2'd3, 1'b1);
        na = 0; ni = 0;
        for (int c = 0; c < 6; c++) begin
            drv(1, 1'b1, 1'b1, lw[na]);
            if (!snk_stall_o[1]) na++;
            if (src_stb_o[1]) begin
                chk("lim_order", 64'(got(1)), 64'(lw[ni]));
                ni++;
            end
            tick();
        end
        chk("lim_stall_set", 64'(snk_stall_o[1]), 64'(1));
        chk("lim_counts", 64'({8'(na), 8'(ni), 7'(0), src_stb_o[1]}), 64'({8'd4, 8'd4, 8'd0}));
        rsp(1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        rsp(1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lim_stall_drop", 64'({snk_stall_o[1], snk_ack_o[1]}), 64'(2'b01));
        drv(1, 1'b0, 1'b0, z);
        tick();
        chk("lim_abort", 64'({src_cyc_o[1], src_stb_o[1]}), 64'(0));

        // ---- ch2 burst of 6 with 4-clk downstream stall from the 2nd issue ----
        for (int k = 0; k < 6; k++) bw[k] = mkreq(2'(k), 16'(16'hB000 + k), 2'(k + 1), 1'(k));
        na = 0; ni = 0; nak = 0; st_left = 0; st_start = -1; st_seen = -1; pend = 0; st_started = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (!st_started && ni == 1 && src_stb_o[2]) begin
                st_started = 1'b1; st_left = 4; st_start = c;
            end
            st_now = (st_left > 0);
            if (st_left > 0) st_left--;
            rsp(2, st_now, 1'(pend), 1'b0, 1'b0);
            if (snk_ack_o[2]) nak++;
            if (st_started && st_seen < 0 && snk_stall_o[2]) st_seen = c;
            if (src_stb_o[2] && !st_now) begin
                if (ni < 6) chk("burst_order", 64'(got(2)), 64'(bw[ni]));
                ni++;
                pend = 1;
            end else pend = 0;
            if (na < 6) begin
                drv(2, 1'b1, 1'b1, bw[na]);
                if (!snk_stall_o[2]) na++;
            end else drv(2, 1'b1, 1'b0, z);
            tick();
        end
        chk("burst_stall_lat", 64'(st_seen >= st_start && st_seen <= st_start + 2 && st_start >= 0), 64'(1));
        chk("burst_counts", 64'({8'(na), 8'(ni), 8'(nak)}), 64'({8'd6, 8'd6, 8'd6}));
        rsp(2, 1'b0, 1'b0, 1'b0, 1'b0);
        drv(2, 1'b0, 1'b0, z);
        tick(); tick();
        chk("burst_cyc_end", 64'(src_cyc_o[2]), 64'(0));

        // ---- ch4 abort with 3 words in flight, late ack, immediate new cycle ----
        for (int k = 0; k < 4; k++) aw[k] = mkreq(2'(k), 16'(16'h4400 + k), 2'd1, 1'b0);
        drv(4, 1'b1, 1'b1, aw[0]); tick();
        drv(4, 1'b1, 1'b1, aw[1]); tick();
        drv(4, 1'b1, 1'b1, aw[2]); rsp(4, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        chk("abort_pre", 64'({snk_stall_o[4], src_stb_o[4], src_cyc_o[4]}), 64'(3'b111));
        drv(4, 1'b0, 1'b0, z); tick();
        chk("abort_flush", 64'({src_cyc_o[4], src_stb_o[4], snk_stall_o[4]}), 64'(0));
        drv(4, 1'b1, 1'b1, aw[3]); rsp(4, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        rsp(4, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort_late_ack", 64'(snk_ack_o[4]), 64'(0));
        chk("abort_new_word", 64'({src_cyc_o[4], src_stb_o[4], got(4)}), 64'({2'b11, aw[3]}));
        drv(4, 1'b1, 1'b0, z); tick();
        rsp(4, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        rsp(4, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort_new_ack", 64'(snk_ack_o[4]), 64'(1));
        drv(4, 1'b0, 1'b0, z); tick();

        // ---- ch3 stalled 10 clk while ch7 streams 10 words ----
        x = mkreq(2'd1, 16'h3333, 2'd1, 1'b1);
        for (int k = 0; k < 10; k++) sw[k] = mkreq(2'(k), 16'(16'h7000 + k), 2'd3, 1'b0);
        drv(3, 1'b1, 1'b1, x); drv(7, 1'b1, 1'b1, sw[0]); tick();
        for (int c = 1; c <= 10; c++) begin
            rsp(3, 1'b1, 1'b0, 1'b0, 1'b0);
            rsp(7, 1'b0, 1'(c > 1), 1'b0, 1'b0);
            chk($sformatf("ind_ch7_c%0d", c), 64'({src_stb_o[7], snk_stall_o[7], got(7)}), 64'({2'b10, sw[c-1]}));
            chk($sformatf("ind_ch3_c%0d", c), 64'({src_stb_o[3], got(3)}), 64'({1'b1, x}));
            drv(3, 1'b1, 1'b0, z);
            if (c < 10) drv(7, 1'b1, 1'b1, sw[c]);
            else        drv(7, 1'b1, 1'b0, z);
            tick();
        end
        rsp(3, 1'b0, 1'b0, 1'b0, 1'b0); rsp(7, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("ind_ch3_held", 64'({src_stb_o[3], got(3)}), 64'({1'b1, x}));
        tick();
        rsp(3, 1'b0, 1'b1, 1'b0, 1'b0); rsp(7, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ind_ch3_issued", 64'({src_stb_o[3], src_stb_o[7]}), 64'(0));
        tick();
        rsp(3, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ind_ch3_ack", 64'(snk_ack_o[3]), 64'(1));
        drv(3, 1'b0, 1'b0, z); drv(7, 1'b0, 1'b0, z);
        tick(); tick();
        chk("ind_cyc_end", 64'({src_cyc_o[3], src_cyc_o[7]}), 64'(0));

        // ---- ch5 reset with 2 words buffered, then a clean transfer ----
        for (int k = 0; k < 3; k++) rw[k] = mkreq(2'(k + 1), 16'(16'h5500 + k), 2'd2, 1'b1);
        drv(5, 1'b1, 1'b1, rw[0]); tick();
        drv(5, 1'b1, 1'b1, rw[1]); rsp(5, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        chk("rst_pre", 64'({snk_stall_o[5], src_stb_o[5]}), 64'(2'b11));
        drv(5, 1'b1, 1'b0, z); rst_i = 1'b1; tick();
        rst_i = 1'b0;
        chk("rst_mid_outputs", 64'({|snk_stall_o, |snk_ack_o, |snk_err_o, |snk_rty_o, |src_dat_o,
                                     |src_adr_o, |src_sel_o, |src_cyc_o, |src_stb_o, |src_we_o}), 64'(0));
        drv(5, 1'b1, 1'b1, rw[2]); rsp(5, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        chk("rst_after_word", 64'({src_cyc_o[5], src_stb_o[5], got(5)}), 64'({2'b11, rw[2]}));
        drv(5, 1'b1, 1'b0, z); tick();
        chk("rst_after_stb", 64'(src_stb_o[5]), 64'(0));
        rsp(5, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        rsp(5, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_after_ack", 64'(snk_ack_o[5]), 64'(1));
        drv(5, 1'b0, 1'b0, z); tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
